// File: rtl/cdb_arbiter.sv
// cdb_arbiter: one holding buffer per FU, arbitrated onto a single registered common data bus.
// Define CDB_ROUND_ROBIN_EN for rotating-priority arbitration; otherwise the lowest FU index wins.
`ifndef ROB_LEN
`define ROB_LEN 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module cdb_arbiter #(
  parameter int NUM_FU = 4,
  parameter int TAG_W  = $clog2(`ROB_LEN),
  parameter int XLEN_P = `XLEN
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_FU-1:0]        fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU*XLEN_P-1:0] fu_value,
  output logic [NUM_FU-1:0]        fu_ready,
  input  logic                     squash,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [XLEN_P-1:0]        cdb_value
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0] buf_valid;
  logic [TAG_W-1:0]  buf_tag   [NUM_FU];
  logic [XLEN_P-1:0] buf_value [NUM_FU];

  logic [NUM_FU-1:0] grant;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_any;
  logic [NUM_FU-1:0] load;

`ifdef CDB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] ptr;

  // Search starts at the pointer and wraps, so every valid buffer is reached within NUM_FU grants.
  always_comb begin
    int              idx;
    logic [PTR_W-1:0] sel;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    sel       = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      sel = idx[PTR_W-1:0];
      if (!grant_any && buf_valid[sel]) begin
        grant_any = 1'b1;
        grant_idx = sel;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (!squash && grant_any) begin
      ptr <= (grant_idx == PTR_W'(NUM_FU - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end
`else
  always_comb begin
    logic [PTR_W-1:0] sel;
    grant_any = 1'b0;
    grant_idx = '0;
    sel       = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      sel = k[PTR_W-1:0];
      if (!grant_any && buf_valid[sel]) begin
        grant_any = 1'b1;
        grant_idx = sel;
      end
    end
  end
`endif

  always_comb begin
    grant = '0;
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  // A granted buffer empties on this edge, so it can take a new result without a bubble.
  assign fu_ready = reset  ? {NUM_FU{1'b1}} :
                    squash ? {NUM_FU{1'b0}} :
                             (~buf_valid | grant);

  assign load = fu_valid & fu_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_valid <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        buf_tag[i]   <= '0;
        buf_value[i] <= '0;
      end
    end else if (squash) begin
      buf_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (load[i]) begin
          buf_valid[i] <= 1'b1;
          buf_tag[i]   <= fu_tag[i*TAG_W +: TAG_W];
          buf_value[i] <= fu_value[i*XLEN_P +: XLEN_P];
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_value <= '0;
    end else if (squash) begin
      cdb_valid <= 1'b0;
    end else if (grant_any) begin
      cdb_valid <= 1'b1;
      cdb_tag   <= buf_tag[grant_idx];
      cdb_value <= buf_value[grant_idx];
    end else begin
      cdb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed CDB scenarios plus randomized traffic checked against a buffer-level model.
module tb_cdb_arbiter;
  localparam int NUM_FU = 4;
  localparam int TAG_W  = 5;
  localparam int XLEN_P = 32;

  logic                     clock = 1'b0;
  logic                     reset = 1'b1;
  logic                     squash = 1'b0;
  logic [NUM_FU-1:0]        fu_valid = '0;
  logic [NUM_FU*TAG_W-1:0]  fu_tag = '0;
  logic [NUM_FU*XLEN_P-1:0] fu_value = '0;
  logic [NUM_FU-1:0]        fu_ready;
  logic                     cdb_valid;
  logic [TAG_W-1:0]         cdb_tag;
  logic [XLEN_P-1:0]        cdb_value;

  cdb_arbiter #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .XLEN_P(XLEN_P)) dut (
    .clock(clock), .reset(reset), .fu_valid(fu_valid), .fu_tag(fu_tag),
    .fu_value(fu_value), .fu_ready(fu_ready), .squash(squash),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // reference model: per-FU buffers and the broadcast register
  bit                m_valid [NUM_FU];
  logic [TAG_W-1:0]  m_tag   [NUM_FU];
  logic [XLEN_P-1:0] m_value [NUM_FU];
  int                m_ptr;
  bit                m_cdb_valid;
  logic [TAG_W-1:0]  m_cdb_tag;
  logic [XLEN_P-1:0] m_cdb_value;
  logic [NUM_FU-1:0] m_ready;
  bit                acc [NUM_FU];

  logic [TAG_W-1:0]  tq [NUM_FU][$];
  logic [XLEN_P-1:0] vq [NUM_FU][$];
  logic [TAG_W-1:0]  seen_tag[$];
  logic [XLEN_P-1:0] seen_val[$];
  int                seen_cyc[$];
  int                cyc;

  function automatic int pick_winner();
    int i;
    for (int k = 0; k < NUM_FU; k++) begin
`ifdef CDB_ROUND_ROBIN_EN
      i = (m_ptr + k) % NUM_FU;
`else
      i = k;
`endif
      if (m_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [TAG_W-1:0] seen_t(int k);
    return (seen_tag.size() > k) ? seen_tag[k] : 'x;
  endfunction

  function automatic int seen_c(int k);
    return (seen_cyc.size() > k) ? seen_cyc[k] : -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_FU; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_value[i] = '0;
      acc[i]     = 1'b0;
      tq[i].delete();
      vq[i].delete();
    end
    m_ptr = 0;
    m_cdb_valid = 1'b0;
    m_cdb_tag = '0;
    m_cdb_value = '0;
    seen_tag.delete();
    seen_val.delete();
    seen_cyc.delete();
    cyc = 0;
  endtask

  // each FU holds its result until accepted, then offers the next queued one
  task automatic drive();
    for (int i = 0; i < NUM_FU; i++) begin
      if (!fu_valid[i] || acc[i]) begin
        if (tq[i].size() > 0) begin
          fu_valid[i] = 1'b1;
          fu_tag[i*TAG_W +: TAG_W] = tq[i].pop_front();
          fu_value[i*XLEN_P +: XLEN_P] = vq[i].pop_front();
        end else begin
          fu_valid[i] = 1'b0;
        end
      end
      acc[i] = 1'b0;
    end
  endtask

  task automatic step();
    int w;
    #1;
    w = pick_winner();
    for (int i = 0; i < NUM_FU; i++) m_ready[i] = !squash && (!m_valid[i] || w == i);
    chk("fu_ready", fu_ready, m_ready);
    @(posedge clock);
    if (squash) begin
      for (int i = 0; i < NUM_FU; i++) m_valid[i] = 1'b0;
      m_cdb_valid = 1'b0;
    end else begin
      if (w >= 0) begin
        m_cdb_valid = 1'b1;
        m_cdb_tag   = m_tag[w];
        m_cdb_value = m_value[w];
        m_valid[w]  = 1'b0;
        m_ptr       = (w + 1) % NUM_FU;
      end else begin
        m_cdb_valid = 1'b0;
      end
      for (int i = 0; i < NUM_FU; i++) begin
        acc[i] = fu_valid[i] && m_ready[i];
        if (acc[i]) begin
          m_valid[i] = 1'b1;
          m_tag[i]   = fu_tag[i*TAG_W +: TAG_W];
          m_value[i] = fu_value[i*XLEN_P +: XLEN_P];
        end
      end
    end
    cyc++;
    @(negedge clock);
    chk("cdb_valid", cdb_valid, m_cdb_valid);
    chk("cdb_tag", cdb_tag, m_cdb_tag);
    chk("cdb_value", cdb_value, m_cdb_value);
    if (cdb_valid) begin
      seen_tag.push_back(cdb_tag);
      seen_val.push_back(cdb_value);
      seen_cyc.push_back(cyc);
    end
  endtask

  task automatic run(int n);
    repeat (n) begin
      drive();
      step();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    squash = 1'b0;
    fu_valid = '0;
    #1;
    chk("rst_cdb_valid", cdb_valid, 1'b0);
    chk("rst_cdb_tag", cdb_tag, '0);
    chk("rst_cdb_value", cdb_value, '0);
    chk("rst_fu_ready", fu_ready, {NUM_FU{1'b1}});
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int exp_seq[4];

    // single uncontended result
    do_reset();
    tq[2].push_back(5'd7); vq[2].push_back(32'hDEAD_BEEF);
    run(5);
    chk("single_count", seen_tag.size(), 1);
    chk("single_tag", seen_t(0), 5'd7);
    chk("single_value", (seen_val.size() > 0) ? seen_val[0] : 'x, 32'hDEAD_BEEF);
    chk("single_latency", seen_c(0), 2);

    // four-way contention
    do_reset();
    for (int i = 0; i < NUM_FU; i++) begin
      tq[i].push_back(TAG_W'(i + 1));
      vq[i].push_back(32'h100 + i);
    end
    run(7);
    chk("contend_count", seen_tag.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("contend_tag", seen_t(k), k + 1);
      chk("contend_cyc", seen_c(k), k + 2);
    end

    // fairness between a streaming FU0 and a single FU1 result
    do_reset();
    tq[0].push_back(5'd10); vq[0].push_back(32'hA0);
    tq[0].push_back(5'd11); vq[0].push_back(32'hA1);
    tq[0].push_back(5'd12); vq[0].push_back(32'hA2);
    tq[1].push_back(5'd20); vq[1].push_back(32'hB0);
`ifdef CDB_ROUND_ROBIN_EN
    exp_seq = '{10, 20, 11, 12};
`else
    exp_seq = '{10, 11, 12, 20};
`endif
    run(8);
    chk("fair_count", seen_tag.size(), 4);
    for (int k = 0; k < 4; k++) chk("fair_tag", seen_t(k), exp_seq[k]);

    // squash before buffered results broadcast
    do_reset();
    tq[1].push_back(5'd5); vq[1].push_back(32'h55);
    tq[3].push_back(5'd6); vq[3].push_back(32'h66);
    run(1);
    drive();
    squash = 1'b1;
    step();
    squash = 1'b0;
    drive();
    #1;
    chk("squash_ready", fu_ready, 4'b1111);
    step();
    run(4);
    chk("squash_no_bcast", seen_tag.size(), 0);

    // reload of a granted buffer on the same edge
    do_reset();
    tq[0].push_back(5'd8); vq[0].push_back(32'h88);
    tq[0].push_back(5'd9); vq[0].push_back(32'h99);
    run(5);
    chk("reload_count", seen_tag.size(), 2);
    chk("reload_tag0", seen_t(0), 5'd8);
    chk("reload_tag1", seen_t(1), 5'd9);
    chk("reload_gap", seen_c(1) - seen_c(0), 1);

    // asynchronous reset while broadcasting, with results still buffered
    do_reset();
    tq[0].push_back(5'd3); vq[0].push_back(32'h33);
    tq[1].push_back(5'd4); vq[1].push_back(32'h44);
    tq[2].push_back(5'd5); vq[2].push_back(32'h55);
    run(2);
    chk("pre_rst_valid", cdb_valid, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", cdb_valid, 1'b0);
    chk("async_rst_tag", cdb_tag, '0);
    do_reset();
    run(5);
    chk("post_rst_no_bcast", seen_tag.size(), 0);

    // randomized traffic with occasional squash
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (tq[i].size() == 0 && $urandom_range(0, 99) < 40) begin
          tq[i].push_back(TAG_W'($urandom));
          vq[i].push_back($urandom);
        end
      end
      squash = ($urandom_range(0, 99) < 4);
      drive();
      step();
    end
    squash = 1'b0;
    run(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
